// File: rtl/avgpool2x2_l2_pkg.sv
// Shared constants for the layer-2 average-pool stage: map dimensions, 9.4 pixel format
// and the controller state encoding.
package avgpool2x2_l2_pkg;

    localparam int unsigned FX_INT_W  = 9;
    localparam int unsigned FX_FRAC_W = 4;
    localparam int unsigned PIX_W     = FX_INT_W + FX_FRAC_W;

    localparam int unsigned L1_DIM = 32;
    localparam int unsigned L2_DIM = 16;

    localparam logic [7:0] L2_LAST_IDX = 8'(L2_DIM * L2_DIM - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRead,
        StWrite,
        StDone
    } state_e;

    // Layer-1 address {row[4:0], col[4:0]} of one tap of the 2x2 window behind output idx.
    function automatic logic [9:0] l1_addr(input logic [7:0] idx, input logic dr,
                                           input logic dc);
        return {idx[7:4], dr, idx[3:0], dc};
    endfunction

endpackage

// File: rtl/avgpool2x2_l2.sv
// 2x2 stride-2 average pooling of the 32x32 layer-1 map into a 16x16 layer-2 map,
// one output pixel every six cycles (four reads, one drain, one write).
module avgpool2x2_l2
    import avgpool2x2_l2_pkg::*;
#(
    parameter int unsigned DATA_W = PIX_W,
    parameter int unsigned ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              crd,
    output logic [ADDR_W-1:0] caddr_rd,
    input  logic [DATA_W-1:0] cdata_rd,
    output logic              cwr,
    output logic [ADDR_W-1:0] caddr_wr,
    output logic [DATA_W-1:0] cdata_wr
);

    // Two spare bits hold the sum of four unsigned samples without overflow.
    localparam int unsigned ACC_W = DATA_W + 2;

    state_e             r_state, w_state_nxt;
    logic [7:0]         r_idx, w_idx_nxt;
    logic [2:0]         r_cnt, w_cnt_nxt;
    logic [ACC_W-1:0]   r_acc, w_acc_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_crd, w_crd_nxt;
    logic               r_cwr, w_cwr_nxt;
    logic [ADDR_W-1:0]  r_caddr_rd, w_caddr_rd_nxt;
    logic [ADDR_W-1:0]  r_caddr_wr, w_caddr_wr_nxt;
    logic [DATA_W-1:0]  r_cdata_wr, w_cdata_wr_nxt;

    logic [ACC_W-1:0]   w_acc_sum;
    logic [ACC_W-1:0]   w_rounded;

    assign w_acc_sum = r_acc + ACC_W'(cdata_rd);
    assign w_rounded = r_acc + ACC_W'(2);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_crd      <= 1'b0;
            r_cwr      <= 1'b0;
            r_caddr_rd <= '0;
            r_caddr_wr <= '0;
            r_cdata_wr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_cnt      <= w_cnt_nxt;
            r_acc      <= w_acc_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_crd      <= w_crd_nxt;
            r_cwr      <= w_cwr_nxt;
            r_caddr_rd <= w_caddr_rd_nxt;
            r_caddr_wr <= w_caddr_wr_nxt;
            r_cdata_wr <= w_cdata_wr_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_crd_nxt      = r_crd;
        w_cwr_nxt      = 1'b0;
        w_caddr_rd_nxt = r_caddr_rd;
        w_caddr_wr_nxt = r_caddr_wr;
        w_cdata_wr_nxt = r_cdata_wr;

        case (r_state)
            StIdle: begin
                if (start) begin
                    w_busy_nxt  = 1'b1;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = StRead;
                end
            end
            StRead: begin
                // Read data lags its address by one cycle, so each step accumulates the
                // sample addressed by the previous step.
                case (r_cnt)
                    3'd0: begin
                        w_acc_nxt      = '0;
                        w_crd_nxt      = 1'b1;
                        w_caddr_rd_nxt = ADDR_W'(l1_addr(r_idx, 1'b0, 1'b0));
                        w_cnt_nxt      = 3'd1;
                    end
                    3'd1: begin
                        w_acc_nxt      = w_acc_sum;
                        w_caddr_rd_nxt = ADDR_W'(l1_addr(r_idx, 1'b0, 1'b1));
                        w_cnt_nxt      = 3'd2;
                    end
                    3'd2: begin
                        w_acc_nxt      = w_acc_sum;
                        w_caddr_rd_nxt = ADDR_W'(l1_addr(r_idx, 1'b1, 1'b0));
                        w_cnt_nxt      = 3'd3;
                    end
                    3'd3: begin
                        w_acc_nxt      = w_acc_sum;
                        w_caddr_rd_nxt = ADDR_W'(l1_addr(r_idx, 1'b1, 1'b1));
                        w_cnt_nxt      = 3'd4;
                    end
                    3'd4: begin
                        w_acc_nxt   = w_acc_sum;
                        w_crd_nxt   = 1'b0;
                        w_state_nxt = StWrite;
                    end
                    default: w_cnt_nxt = '0;
                endcase
            end
            StWrite: begin
                w_cwr_nxt      = 1'b1;
                w_caddr_wr_nxt = ADDR_W'(r_idx);
                w_cdata_wr_nxt = w_rounded[ACC_W-1:2];
                w_cnt_nxt      = '0;
                if (r_idx == L2_LAST_IDX) begin
                    w_state_nxt = StDone;
                end else begin
                    w_idx_nxt   = r_idx + 8'd1;
                    w_state_nxt = StRead;
                end
            end
            StDone: begin
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                w_state_nxt = StIdle;
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign crd      = r_crd;
    assign caddr_rd = r_caddr_rd;
    assign cwr      = r_cwr;
    assign caddr_wr = r_caddr_wr;
    assign cdata_wr = r_cdata_wr;

endmodule

// File: tb/tb_avgpool2x2_l2.sv
// Directed bench for avgpool2x2_l2: combinational layer-1 memory model, write capture on
// the falling edge, hand-computed expected outputs.
module tb_avgpool2x2_l2;

    localparam int unsigned DW = 13;
    localparam int unsigned AW = 12;
    localparam int FRAME_CYC = 1538;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;

    logic [DW-1:0] mem [0:4095];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cdata_rd = mem[caddr_rd];

    avgpool2x2_l2 #(
        .DATA_W(DW),
        .ADDR_W(AW)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .crd     (crd),
        .caddr_rd(caddr_rd),
        .cdata_rd(cdata_rd),
        .cwr     (cwr),
        .caddr_wr(caddr_wr),
        .cdata_wr(cdata_wr)
    );

    always @(negedge clk) begin
        if (cwr) begin
            wr_addr_q.push_back(caddr_wr);
            wr_data_q.push_back(cdata_wr);
        end
    end

    task automatic fill_const(input logic [DW-1:0] val);
        for (int i = 0; i < 1024; i++) mem[i] = val;
    endtask

    task automatic fill_ramp();
        for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
    endtask

    // Pulses start, optionally pulses it again at cycle pulse_at, and waits for done.
    // cycles = cycles from the start edge to done visible; busy_low counts busy drops.
    task automatic run_frame(input int pulse_at, output int cycles, output int busy_low);
        wr_addr_q.delete();
        wr_data_q.delete();
        cycles   = 0;
        busy_low = 0;
        @(negedge clk);
        start = 1'b1;
        while (cycles <= 2000) begin
            @(negedge clk);
            cycles++;
            start = (cycles == pulse_at);
            if (done) break;
            if (!busy) busy_low++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, crd, cwr} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_flags: got busy/done/crd/cwr=%b want 0000",
                     {busy, done, crd, cwr});
        end
        n_vec++;
        if (caddr_rd !== '0) begin
            n_err++;
            $display("FAIL reset_caddr_rd: got %0d want 0", caddr_rd);
        end
        n_vec++;
        if (caddr_wr !== '0 || cdata_wr !== '0) begin
            n_err++;
            $display("FAIL reset_wr: got addr=%0d data=%0d want 0/0", caddr_wr, cdata_wr);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_constant();
        int cyc;
        int bl;
        fill_const(13'h0100);
        run_frame(-1, cyc, bl);
        n_vec++;
        if (cyc !== FRAME_CYC) begin
            n_err++;
            $display("FAIL const_cycles: got %0d want %0d", cyc, FRAME_CYC);
        end
        n_vec++;
        if (bl !== 0) begin
            n_err++;
            $display("FAIL const_busy: busy low %0d cycles want 0", bl);
        end
        n_vec++;
        if (wr_addr_q.size() !== 256) begin
            n_err++;
            $display("FAIL const_count: got %0d writes want 256", wr_addr_q.size());
        end
        for (int i = 0; i < wr_addr_q.size(); i++) begin
            n_vec++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== 13'h0100) begin
                n_err++;
                $display("FAIL const_px%0d: got addr=%0d data=%h want addr=%0d data=0100",
                         i, wr_addr_q[i], wr_data_q[i], i);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({done, busy} !== 2'b00) begin
            n_err++;
            $display("FAIL done_pulse: got done/busy=%b a cycle later want 00", {done, busy});
        end
    endtask

    task automatic test_rounding();
        int cyc;
        int bl;
        int nz;
        logic [DW-1:0] exp_q[4];
        fill_const('0);
        // Block 0: {1,1,1,0}; block 1: {1,1,0,0}; block 2: {1,0,0,0}; block 3: {2,0,0,0}.
        mem[0] = 13'd1; mem[1] = 13'd1; mem[32] = 13'd1;
        mem[2] = 13'd1; mem[3] = 13'd1;
        mem[4] = 13'd1;
        mem[6] = 13'd2;
        exp_q[0] = 13'd1; exp_q[1] = 13'd1; exp_q[2] = 13'd0; exp_q[3] = 13'd1;
        run_frame(-1, cyc, bl);
        n_vec++;
        if (wr_data_q.size() !== 256) begin
            n_err++;
            $display("FAIL round_count: got %0d writes want 256", wr_data_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (wr_data_q[i] !== exp_q[i]) begin
                    n_err++;
                    $display("FAIL round_blk%0d: got %0d want %0d", i, wr_data_q[i], exp_q[i]);
                end
            end
            nz = 0;
            for (int i = 4; i < 256; i++) if (wr_data_q[i] !== '0) nz++;
            n_vec++;
            if (nz !== 0) begin
                n_err++;
                $display("FAIL round_rest: got %0d nonzero outputs want 0", nz);
            end
        end
    endtask

    task automatic test_max();
        int cyc;
        int bl;
        fill_const(13'd8191);
        run_frame(-1, cyc, bl);
        n_vec++;
        if (wr_data_q.size() !== 256) begin
            n_err++;
            $display("FAIL max_count: got %0d writes want 256", wr_data_q.size());
        end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            n_vec++;
            if (wr_data_q[i] !== 13'd8191) begin
                n_err++;
                $display("FAIL max_px%0d: got %0d want 8191", i, wr_data_q[i]);
            end
        end
    endtask

    task automatic test_ramp();
        int cyc;
        int bl;
        int exp_v;
        fill_ramp();
        run_frame(-1, cyc, bl);
        n_vec++;
        if (wr_data_q.size() !== 256) begin
            n_err++;
            $display("FAIL ramp_count: got %0d writes want 256", wr_data_q.size());
        end
        for (int i = 0; i < wr_data_q.size(); i++) begin
            exp_v = 64 * (i / 16) + 2 * (i % 16) + 17;
            n_vec++;
            if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== DW'(exp_v)) begin
                n_err++;
                $display("FAIL ramp_px%0d: got addr=%0d data=%0d want addr=%0d data=%0d",
                         i, wr_addr_q[i], wr_data_q[i], i, exp_v);
            end
        end
    endtask

    task automatic test_reset_midrun();
        int cyc;
        int bl;
        fill_ramp();
        wr_addr_q.delete();
        wr_data_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // Now past the start edge; 602 more edges lands inside the READ of idx 100.
        repeat (602) @(negedge clk);
        n_vec++;
        if (wr_addr_q.size() !== 100) begin
            n_err++;
            $display("FAIL midrst_pre: got %0d writes want 100", wr_addr_q.size());
        end
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({busy, done, crd, cwr} !== 4'b0000) begin
            n_err++;
            $display("FAIL midrst_flags: got busy/done/crd/cwr=%b want 0000",
                     {busy, done, crd, cwr});
        end
        n_vec++;
        if (caddr_rd !== '0 || caddr_wr !== '0 || cdata_wr !== '0) begin
            n_err++;
            $display("FAIL midrst_regs: got rd=%0d wr=%0d data=%0d want 0/0/0",
                     caddr_rd, caddr_wr, cdata_wr);
        end
        reset = 1'b0;
        repeat (20) @(negedge clk);
        n_vec++;
        if (wr_addr_q.size() !== 100 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_idle: got writes=%0d busy=%b want 100/0",
                     wr_addr_q.size(), busy);
        end
        run_frame(-1, cyc, bl);
        n_vec++;
        if (cyc !== FRAME_CYC) begin
            n_err++;
            $display("FAIL midrst_cycles: got %0d want %0d", cyc, FRAME_CYC);
        end
        n_vec++;
        if (wr_addr_q.size() === 0 || wr_addr_q[0] !== '0 || wr_data_q[0] !== 13'd17) begin
            n_err++;
            $display("FAIL midrst_first: got writes=%0d first addr/data wrong want 0/17",
                     wr_addr_q.size());
        end
    endtask

    task automatic test_start_midrun();
        int cyc;
        int bl;
        int bad;
        fill_ramp();
        // Cycle 303 is inside the READ of idx 50.
        run_frame(303, cyc, bl);
        n_vec++;
        if (cyc !== FRAME_CYC) begin
            n_err++;
            $display("FAIL midstart_cycles: got %0d want %0d", cyc, FRAME_CYC);
        end
        n_vec++;
        if (bl !== 0) begin
            n_err++;
            $display("FAIL midstart_busy: busy low %0d cycles want 0", bl);
        end
        bad = 0;
        for (int i = 0; i < wr_addr_q.size(); i++) if (wr_addr_q[i] !== AW'(i)) bad++;
        n_vec++;
        if (wr_addr_q.size() !== 256 || bad !== 0) begin
            n_err++;
            $display("FAIL midstart_addr: got %0d writes, %0d out of order want 256/0",
                     wr_addr_q.size(), bad);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        test_reset();
        test_constant();
        test_rounding();
        test_max();
        test_ramp();
        test_reset_midrun();
        test_start_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
